// File: rtl/convolutor_pkg.sv
// Shared types and default geometry for the convolutor ROM and its read-side stream reader.
package convolutor_pkg;

    localparam int ROM_WIDTH = 8;
    localparam int ROM_DEPTH = 32;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} rd_state_e;

endpackage

// File: rtl/convolutor_skid_fifo.sv
// Purpose: 2-entry FIFO whose head entry drives the stream outputs directly from registers.
// Latency: a pushed word is visible at the head the cycle after the push.
// Backpressure: head holds while pop is low; push and pop together are accepted at any occupancy.
module convolutor_skid_fifo
    import convolutor_pkg::*;
#(
    parameter int WIDTH = ROM_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic             head_vld,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] entry0_q;
    logic [WIDTH-1:0] entry1_q;
    logic [1:0]       count_q;
    logic             pop_eff;

    assign pop_eff  = pop && (count_q != 2'd0);
    assign head_dat = entry0_q;
    assign head_vld = (count_q != 2'd0);
    assign count    = count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry0_q <= '0;
            entry1_q <= '0;
            count_q  <= 2'd0;
        end else begin
            case ({push, pop_eff})
                2'b10: begin
                    if (count_q == 2'd0)
                        entry0_q <= push_dat;
                    else if (count_q == 2'd1)
                        entry1_q <= push_dat;
                    if (count_q != 2'd2)
                        count_q <= count_q + 2'd1;
                end
                2'b01: begin
                    entry0_q <= entry1_q;
                    count_q  <= count_q - 2'd1;
                end
                2'b11: begin
                    // occupancy is unchanged; the new word lands behind whatever remains
                    if (count_q == 2'd1) begin
                        entry0_q <= push_dat;
                    end else begin
                        entry0_q <= entry1_q;
                        entry1_q <= push_dat;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/convolutor_rom_stream_reader.sv
// Purpose: sweeps LEN ROM addresses from BASE (mod DEPTH) and streams the words out valid/ready.
// Latency: first word valid 3 cycles after an accepted start, then one word per cycle.
// Backpressure: reads throttle so FIFO plus in-flight never exceed 2; data_o holds while stalled.
module convolutor_rom_stream_reader
    import convolutor_pkg::*;
#(
    parameter  int WIDTH = ROM_WIDTH,
    parameter  int DEPTH = ROM_DEPTH,
    localparam int ADDRW = $clog2(DEPTH),
    localparam int LENW  = ADDRW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [ADDRW-1:0] base_i,
    input  logic [LENW-1:0]  length_i,
    output logic [ADDRW-1:0] read_address_o,
    input  logic [WIDTH-1:0] read_data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             busy_o,
    output logic             done_o
);

    rd_state_e        state_q;
    rd_state_e        state_d;
    logic [LENW-1:0]  len_q;
    logic [LENW-1:0]  issued_q;
    logic [LENW-1:0]  delivered_q;
    logic             inflight_q;
    logic [1:0]       fifo_cnt;
    logic [2:0]       occ;
    logic             issue;
    logic             xfer;
    logic             accept;
    logic [ADDRW-1:0] addr_next;

    assign xfer      = valid_o && ready_i;
    assign accept    = (state_q == IDLE) && start_i;
    assign occ       = {1'b0, fifo_cnt} + {2'b00, inflight_q};
    assign addr_next = (read_address_o == ADDRW'(DEPTH - 1)) ? '0 : read_address_o + ADDRW'(1);

    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        case (state_q)
            IDLE:  if (start_i) state_d = (length_i == '0) ? DONE : RUN;
            RUN: begin
                // a same-cycle pop frees a slot, which keeps the stream at full rate
                issue = (issued_q != len_q) && (occ < (xfer ? 3'd3 : 3'd2));
                if (issued_q == len_q) state_d = DRAIN;
            end
            DRAIN: if ((fifo_cnt == 2'd0) && !inflight_q && (delivered_q == len_q)) state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            read_address_o <= '0;
            len_q          <= '0;
            issued_q       <= '0;
            delivered_q    <= '0;
            inflight_q     <= 1'b0;
        end else begin
            inflight_q <= issue;
            if (accept) begin
                len_q       <= length_i;
                issued_q    <= '0;
                delivered_q <= '0;
                if (length_i != '0) read_address_o <= base_i;
            end else begin
                if (issue) begin
                    read_address_o <= addr_next;
                    issued_q       <= issued_q + LENW'(1);
                end
                if (xfer) delivered_q <= delivered_q + LENW'(1);
            end
        end
    end

    convolutor_skid_fifo #(.WIDTH(WIDTH)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (inflight_q),
        .push_dat (read_data_i),
        .pop      (ready_i),
        .head_dat (data_o),
        .head_vld (valid_o),
        .count    (fifo_cnt)
    );

    assign busy_o = (state_q == RUN) || (state_q == DRAIN);
    assign done_o = (state_q == DONE);

endmodule

// File: tb/tb_convolutor_rom_stream_reader.sv
// Drives sweeps against a behavioural 1-cycle ROM and scoreboards the stream against a queue model.
module tb_convolutor_rom_stream_reader;

    localparam int WIDTH = 8;
    localparam int DEPTH = 32;
    localparam int ADDRW = 5;
    localparam int LENW  = 6;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             start_i = 1'b0;
    logic [ADDRW-1:0] base_i = '0;
    logic [LENW-1:0]  length_i = '0;
    logic [ADDRW-1:0] read_address_o;
    logic [WIDTH-1:0] read_data_i;
    logic [WIDTH-1:0] data_o;
    logic             valid_o;
    logic             ready_i = 1'b0;
    logic             busy_o;
    logic             done_o;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] exp_q [$];
    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int first_x = -1;
    int last_x = -1;
    int xfer_cnt = 0;
    bit prev_stall = 1'b0;
    logic [WIDTH-1:0] prev_dat = '0;

    convolutor_rom_stream_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start_i        (start_i),
        .base_i         (base_i),
        .length_i       (length_i),
        .read_address_o (read_address_o),
        .read_data_i    (read_data_i),
        .data_o         (data_o),
        .valid_o        (valid_o),
        .ready_i        (ready_i),
        .busy_o         (busy_o),
        .done_o         (done_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) read_data_i <= mem[read_address_o];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: samples 1 time unit after each negedge, i.e. well away from the posedge.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_hold_vld", 32'(valid_o), 32'd1);
                    check("stall_hold_dat", 32'(data_o), 32'(prev_dat));
                end
                if (valid_o && ready_i) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_xfer: got data %0d with nothing expected", data_o);
                    end else begin
                        check("xfer_dat", 32'(data_o), 32'(exp_q.pop_front()));
                    end
                    if (first_x < 0) first_x = cyc;
                    last_x = cyc;
                    xfer_cnt++;
                end
                if (done_o) begin
                    done_cnt++;
                    done_cyc = cyc;
                    check("busy_low_at_done", 32'(busy_o), 32'd0);
                end
                prev_stall = valid_o && !ready_i;
                prev_dat   = data_o;
            end
        end
    end

    task automatic sweep(input int base, input int len, input bit rnd_ready, input bit mid_start);
        int start_cyc;
        logic [ADDRW-1:0] addr0;
        bit got;
        @(negedge clk);
        for (int k = 0; k < len; k++) exp_q.push_back(mem[(base + k) % DEPTH]);
        done_cnt = 0;
        first_x  = -1;
        last_x   = -1;
        xfer_cnt = 0;
        addr0    = read_address_o;
        start_i  = 1'b1;
        base_i   = ADDRW'(base);
        length_i = LENW'(len);
        ready_i  = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        start_cyc = cyc;
        got = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            start_i = mid_start && (i == 4);
            if (mid_start && i == 4) begin
                base_i   = ADDRW'(20);
                length_i = LENW'(9);
            end
            ready_i = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (i == 0) begin
                #1;
                check("busy_after_start", 32'(busy_o), 32'(len != 0));
            end
            if (done_cnt != 0) got = 1'b1;
        end
        repeat (3) @(negedge clk);
        check("done_pulses", 32'(done_cnt), 32'd1);
        check("leftover_words", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        check("xfer_count", 32'(xfer_cnt), 32'(len));
        check("busy_idle", 32'(busy_o), 32'd0);
        if (len == 0) begin
            check("zero_addr_hold", 32'(read_address_o), 32'(addr0));
            check("zero_done_lat", 32'((done_cyc - start_cyc) inside {1, 2}), 32'd1);
        end else begin
            check("done_after_last", 32'(done_cyc - last_x), 32'd2);
            if (!rnd_ready) begin
                check("first_latency", 32'(first_x - start_cyc), 32'd3);
                check("burst_span", 32'(last_x - first_x), 32'(len - 1));
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_addr"},  32'(read_address_o), 32'd0);
        check({tag, "_data"},  32'(data_o),         32'd0);
        check({tag, "_valid"}, 32'(valid_o),        32'd0);
        check({tag, "_busy"},  32'(busy_o),         32'd0);
        check({tag, "_done"},  32'(done_o),         32'd0);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = WIDTH'(i);
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;

        sweep(0, 32, 1'b0, 1'b0);
        sweep(30, 4, 1'b0, 1'b0);
        sweep(5, 6, 1'b1, 1'b0);
        sweep(9, 0, 1'b0, 1'b0);
        sweep(10, 12, 1'b0, 1'b1);

        // asynchronous reset in the middle of a sweep
        @(negedge clk);
        for (int k = 0; k < 20; k++) exp_q.push_back(mem[(7 + k) % DEPTH]);
        start_i  = 1'b1;
        base_i   = ADDRW'(7);
        length_i = LENW'(20);
        ready_i  = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (6) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        sweep(3, 2, 1'b0, 1'b0);

        repeat (10) begin
            for (int i = 0; i < DEPTH; i++) mem[i] = WIDTH'($urandom);
            sweep(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, DEPTH)),
                  1'($urandom_range(0, 1)), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
